// File: rtl/datamover_mc_fsm_pkg.sv
// rtl/datamover_mc_fsm_pkg.sv - shared types for the multi-channel datamover control FSM
package datamover_mc_fsm_pkg;

  localparam int unsigned DM_NB_CH  = 4;
  localparam int unsigned DM_ADDR_W = 32;
  localparam int unsigned DM_LEN_W  = 16;

  typedef enum logic [2:0] {
    DM_IDLE   = 3'd0,
    DM_LAUNCH = 3'd1,
    DM_WAIT   = 3'd2,
    DM_DRAIN  = 3'd3,
    DM_FINISH = 3'd4
  } dm_state_e;

  typedef enum logic {
    DM_SEQ  = 1'b0,
    DM_CONC = 1'b1
  } dm_mode_e;

  // Register-file view of one channel and of the status flags at default widths
  typedef struct packed {
    logic [DM_ADDR_W-1:0] src_addr;
    logic [DM_ADDR_W-1:0] dst_addr;
    logic [DM_LEN_W-1:0]  len;
  } ctrl_dm_ch_t;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic [DM_NB_CH-1:0] ch_done;
    logic [DM_LEN_W-1:0] cycles;
  } flags_dm_t;

endpackage

// File: rtl/datamover_mc_fsm_ch_tracker.sv
// rtl/datamover_mc_fsm_ch_tracker.sv - per-channel seen-bit capture, pending and sticky done
module datamover_ch_tracker (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic snap_i,
  input  logic snap_en_i,
  input  logic snap_zero_i,
  input  logic launch_i,
  input  logic retire_i,
  input  logic src_done_i,
  input  logic snk_done_i,
  output logic pending_o,
  output logic both_o,
  output logic ch_done_o
);

  logic launched;
  logic src_seen;
  logic snk_seen;

  assign both_o = src_seen & snk_seen;

  // launched is set on the same edge as the start pulse, so dones in the launch cycle are kept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_o <= 1'b0;
      ch_done_o <= 1'b0;
      launched  <= 1'b0;
      src_seen  <= 1'b0;
      snk_seen  <= 1'b0;
    end else if (clear_i) begin
      pending_o <= 1'b0;
      ch_done_o <= 1'b0;
      launched  <= 1'b0;
      src_seen  <= 1'b0;
      snk_seen  <= 1'b0;
    end else if (snap_i) begin
      pending_o <= snap_en_i;
      ch_done_o <= snap_zero_i;
      launched  <= launch_i;
      src_seen  <= 1'b0;
      snk_seen  <= 1'b0;
    end else begin
      launched <= launched | launch_i;
      if (launched) begin
        src_seen <= src_seen | src_done_i;
        snk_seen <= snk_seen | snk_done_i;
      end
      if (retire_i) begin
        pending_o <= 1'b0;
        ch_done_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/datamover_mc_fsm.sv
// rtl/datamover_mc_fsm.sv - multi-channel datamover control FSM: launch, track, drain, complete
module datamover_mc_fsm
  import datamover_mc_fsm_pkg::*;
#(
  parameter int unsigned NB_CH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [NB_CH-1:0]        ch_mask_i,
  input  logic [NB_CH*ADDR_W-1:0] src_addr_i,
  input  logic [NB_CH*ADDR_W-1:0] dst_addr_i,
  input  logic [NB_CH*LEN_W-1:0]  len_i,
  input  logic [NB_CH-1:0]        src_done_i,
  input  logic [NB_CH-1:0]        snk_done_i,
  input  logic                    tcdm_fifo_empty_i,
  output logic [NB_CH-1:0]        src_start_o,
  output logic [NB_CH-1:0]        snk_start_o,
  output logic [NB_CH*ADDR_W-1:0] src_addr_o,
  output logic [NB_CH*ADDR_W-1:0] dst_addr_o,
  output logic [NB_CH*LEN_W-1:0]  len_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NB_CH-1:0]        ch_done_o,
  output logic [LEN_W-1:0]        cycles_o
);

  dm_state_e  state;
  dm_mode_e   mode_q;

  logic [NB_CH-1:0] pending;
  logic [NB_CH-1:0] both;
  logic [NB_CH-1:0] len_nz;
  logic [NB_CH-1:0] eff_mask;
  logic [NB_CH-1:0] launch;
  logic [NB_CH-1:0] retire;
  logic [NB_CH-1:0] next_pend;
  logic             accept;

  // Priority encoder: one-hot of the lowest set bit
  function automatic logic [NB_CH-1:0] lowest_set(input logic [NB_CH-1:0] v);
    lowest_set = v & (~v + NB_CH'(1));
  endfunction

  always_comb begin
    for (int c = 0; c < NB_CH; c++) begin
      len_nz[c] = |len_i[c*LEN_W +: LEN_W];
    end
    eff_mask = ch_mask_i & len_nz;
    accept   = (state == DM_IDLE) && start_i;
    retire   = '0;
    if (state == DM_WAIT) begin
      retire = (mode_q == DM_SEQ) ? (lowest_set(pending) & both) : (pending & both);
    end
    next_pend = pending & ~retire;
    launch    = '0;
    if (accept) begin
      launch = (mode_i == 1'b1) ? eff_mask : lowest_set(eff_mask);
    end else if ((state == DM_WAIT) && (mode_q == DM_SEQ) && (retire != '0)) begin
      launch = lowest_set(next_pend);
    end
  end

  for (genvar c = 0; c < NB_CH; c++) begin : g_trk
    datamover_ch_tracker u_trk (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .snap_i     (accept),
      .snap_en_i  (eff_mask[c]),
      .snap_zero_i(ch_mask_i[c] & ~len_nz[c]),
      .launch_i   (launch[c]),
      .retire_i   (retire[c]),
      .src_done_i (src_done_i[c]),
      .snk_done_i (snk_done_i[c]),
      .pending_o  (pending[c]),
      .both_o     (both[c]),
      .ch_done_o  (ch_done_o[c])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= DM_IDLE;
      mode_q      <= DM_SEQ;
      src_start_o <= '0;
      snk_start_o <= '0;
      src_addr_o  <= '0;
      dst_addr_o  <= '0;
      len_o       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cycles_o    <= '0;
    end else if (clear_i) begin
      state       <= DM_IDLE;
      mode_q      <= DM_SEQ;
      src_start_o <= '0;
      snk_start_o <= '0;
      src_addr_o  <= '0;
      dst_addr_o  <= '0;
      len_o       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cycles_o    <= '0;
    end else begin
      src_start_o <= launch;
      snk_start_o <= launch;
      done_o      <= 1'b0;
      if (busy_o && (cycles_o != '1)) begin
        cycles_o <= cycles_o + LEN_W'(1);
      end
      case (state)
        DM_IDLE: begin
          if (start_i) begin
            mode_q     <= dm_mode_e'(mode_i);
            src_addr_o <= src_addr_i;
            dst_addr_o <= dst_addr_i;
            len_o      <= len_i;
            cycles_o   <= '0;
            busy_o     <= 1'b1;
            state      <= (eff_mask != '0) ? DM_LAUNCH : DM_DRAIN;
          end
        end
        DM_LAUNCH: state <= DM_WAIT;
        DM_WAIT: begin
          // Concurrent mode retires channels as they complete and stays here until none remain
          if (retire != '0) begin
            if (next_pend == '0) begin
              state <= DM_DRAIN;
            end else if (mode_q == DM_SEQ) begin
              state <= DM_LAUNCH;
            end
          end
        end
        DM_DRAIN: begin
          if (tcdm_fifo_empty_i) begin
            state  <= DM_FINISH;
            done_o <= 1'b1;
          end
        end
        DM_FINISH: begin
          state  <= DM_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

endmodule
